// File: rtl/ascon_perm_sequencer.sv
// ascon_perm_sequencer: control FSM for one ASCON p^a / p^b permutation call.
// It drives the datapath's state-select, round index and state-register enable.
// Handshake: start_i is accepted while ready_o=1; done_o pulses for one cycle at the end.
// Optional abort input is enabled by defining ASCON_PERM_SEQ_ABORT_EN.
module ascon_perm_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 8
) (
    input  logic       clock_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       sel_b_i,
`ifdef ASCON_PERM_SEQ_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       ready_o,
    output logic       busy_o,
    output logic       init_state_o,
    output logic [3:0] round_o,
    output logic       perm_en_o,
    output logic       done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Rounds always end at index 11, so the first index is 12-N.
    localparam logic [3:0] START_A = 4'(12 - ROUNDS_A);
    localparam logic [3:0] START_B = 4'(12 - ROUNDS_B);
    localparam logic [3:0] LAST    = 4'd11;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       abort;

`ifdef ASCON_PERM_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    // State, round counter and latched p^a/p^b selection.
    always_ff @(posedge clock_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state logic. All outputs are decoded from registered state only.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        ready_o      = 1'b0;
        busy_o       = 1'b0;
        init_state_o = 1'b0;
        round_o      = 4'd0;
        perm_en_o    = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    sel_d   = sel_b_i;
                    cnt_d   = sel_b_i ? START_B : START_A;
                    state_d = FIRST;
                end
            end
            FIRST: begin
                init_state_o = 1'b1;
                perm_en_o    = 1'b1;
                busy_o       = 1'b1;
                round_o      = cnt_q;
                if (abort) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if ((sel_q ? START_B : START_A) == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                perm_en_o = 1'b1;
                busy_o    = 1'b1;
                round_o   = cnt_q;
                if (abort) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_perm_sequencer.sv
// Directed testbench for ascon_perm_sequencer (default parameters plus a ROUNDS_A=1 instance).
module tb_ascon_perm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, sel = 1'b0;
    logic       ready, busy, init_st, perm_en, done;
    logic [3:0] round;
    logic       start1 = 1'b0, sel1 = 1'b0;
    logic       ready1, busy1, init1, perm_en1, done1;
    logic [3:0] round1;
`ifdef ASCON_PERM_SEQ_ABORT_EN
    logic       abort = 1'b0, abort1 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_perm_sequencer dut (
        .clock_i(clk), .rst_i(rst_n), .start_i(start), .sel_b_i(sel),
`ifdef ASCON_PERM_SEQ_ABORT_EN
        .abort_i(abort),
`endif
        .ready_o(ready), .busy_o(busy), .init_state_o(init_st),
        .round_o(round), .perm_en_o(perm_en), .done_o(done)
    );

    ascon_perm_sequencer #(.ROUNDS_A(1), .ROUNDS_B(8)) dut1 (
        .clock_i(clk), .rst_i(rst_n), .start_i(start1), .sel_b_i(sel1),
`ifdef ASCON_PERM_SEQ_ABORT_EN
        .abort_i(abort1),
`endif
        .ready_o(ready1), .busy_o(busy1), .init_state_o(init1),
        .round_o(round1), .perm_en_o(perm_en1), .done_o(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and check round sequence, busy/perm_en length and a single done pulse.
    task automatic run_seq(input logic s, input int n, input int first_round, input string tag);
        int pe = 0, bz = 0, dn = 0;
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        tick();
        start = 1'b0;
        chk({tag, "_init"}, {31'd0, init_st}, 32'd1);
        for (int i = 0; i < n + 3; i++) begin
            if (perm_en) begin
                chk({tag, "_round"}, {28'd0, round}, 32'(first_round + pe));
                pe++;
            end
            if (busy) bz++;
            if (done) dn++;
            tick();
        end
        chk({tag, "_perm_cycles"}, 32'(pe), 32'(n));
        chk({tag, "_busy_cycles"}, 32'(bz), 32'(n));
        chk({tag, "_done_count"}, 32'(dn), 32'd1);
        chk({tag, "_ready_end"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int t_init [4];
        int r_init [4];
        int n_init;
        int d;

        // Reset values
        #2;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outs", {28'd0, init_st, perm_en, done, 1'b0}, 32'd0);
        chk("rst_round", {28'd0, round}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // p12 with detailed timing
        @(negedge clk);
        start = 1'b1;
        sel   = 1'b0;
        tick();
        start = 1'b0;
        chk("p12_first_init", {31'd0, init_st}, 32'd1);
        chk("p12_first_round", {28'd0, round}, 32'd0);
        chk("p12_first_perm", {31'd0, perm_en}, 32'd1);
        chk("p12_first_busy", {31'd0, busy}, 32'd1);
        chk("p12_first_ready", {31'd0, ready}, 32'd0);
        for (int k = 1; k < 12; k++) begin
            tick();
            chk("p12_round", {28'd0, round}, 32'(k));
            chk("p12_init_low", {31'd0, init_st}, 32'd0);
            chk("p12_perm", {31'd0, perm_en}, 32'd1);
        end
        tick();
        chk("p12_done", {31'd0, done}, 32'd1);
        chk("p12_done_ready", {31'd0, ready}, 32'd0);
        chk("p12_done_busy", {31'd0, busy}, 32'd0);
        chk("p12_done_perm", {31'd0, perm_en}, 32'd0);
        tick();
        chk("p12_after_done", {31'd0, done}, 32'd0);
        chk("p12_after_ready", {31'd0, ready}, 32'd1);

        // p8
        run_seq(1'b1, 8, 4, "p8");

        // Continuous start with alternating sel: spacing and sel ignored mid-run
        n_init = 0;
        for (int i = 0; i < 4; i++) begin
            t_init[i] = 0;
            r_init[i] = 0;
        end
        @(negedge clk);
        start = 1'b1;
        sel   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (init_st && n_init < 4) begin
                t_init[n_init] = c;
                r_init[n_init] = 32'(round);
                n_init++;
                sel = ~sel;
            end
            if (busy && !init_st && t_init[0] == 0 && n_init == 1 && c == 5)
                chk("b2b_mid_round", {28'd0, round}, 32'd5);
        end
        start = 1'b0;
        chk("b2b_count", 32'(n_init >= 3), 32'd1);
        chk("b2b_r0", 32'(r_init[0]), 32'd0);
        chk("b2b_r1", 32'(r_init[1]), 32'd4);
        chk("b2b_r2", 32'(r_init[2]), 32'd0);
        chk("b2b_space_p12", 32'(t_init[1] - t_init[0]), 32'd14);
        chk("b2b_space_p8", 32'(t_init[2] - t_init[1]), 32'd10);
        d = 0;
        while (!ready && d < 20) begin
            tick();
            d++;
        end
        chk("b2b_idle_timeout", {31'd0, ready}, 32'd1);

        // Asynchronous reset mid-run at round 6
        @(negedge clk);
        start = 1'b1;
        sel   = 1'b0;
        tick();
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_pre_round", {28'd0, round}, 32'd6);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_round", {28'd0, round}, 32'd0);
        chk("arst_outs", {29'd0, init_st, perm_en, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d = 0;
        repeat (15) begin
            tick();
            if (done) d++;
        end
        chk("arst_no_done", 32'(d), 32'd0);
        run_seq(1'b0, 12, 0, "post_rst");

        // ROUNDS_A=1 instance
        @(negedge clk);
        start1 = 1'b1;
        sel1   = 1'b0;
        tick();
        start1 = 1'b0;
        chk("n1_init", {31'd0, init1}, 32'd1);
        chk("n1_round", {28'd0, round1}, 32'd11);
        chk("n1_perm", {31'd0, perm_en1}, 32'd1);
        tick();
        chk("n1_done", {31'd0, done1}, 32'd1);
        chk("n1_perm_off", {31'd0, perm_en1}, 32'd0);
        tick();
        chk("n1_ready", {31'd0, ready1}, 32'd1);
        chk("n1_done_off", {31'd0, done1}, 32'd0);

`ifdef ASCON_PERM_SEQ_ABORT_EN
        // Abort at round 9 of a p12 call
        @(negedge clk);
        start = 1'b1;
        sel   = 1'b0;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("abort_pre_round", {28'd0, round}, 32'd9);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_perm", {31'd0, perm_en}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        d = 0;
        repeat (5) begin
            tick();
            if (done) d++;
        end
        chk("abort_no_done", 32'(d), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ascon_perm_sequencer.md
Name: ascon_perm_sequencer

Overview:
Control FSM that sequences the ASCON permutation datapath (constant addition, substitution, diffusion, state register) for one p^a or p^b call.
- Drives the datapath's state-select (load external state vs. feed back registered state), the 4-bit round index and a state-register enable.
- Sits between the AEAD top-level FSM, which requests permutation calls, and the permutation datapath.
- Uses a ready/start request handshake and returns a one-cycle done pulse.

Parameters:
ROUNDS_A, 12, round count for p^a (initialisation/finalisation); legal 1..12
ROUNDS_B, 8, round count for p^b (data processing); legal 1..12

Ports:
clock_i  input  1  system clock, rising edge
rst_i  input  1  reset, asynchronous, active-low
start_i  input  1  permutation request; accepted when ready_o=1
sel_b_i  input  1  0 = run ROUNDS_A rounds, 1 = run ROUNDS_B rounds; sampled with start_i
ready_o  output  1  sequencer idle, can accept start_i
busy_o  output  1  permutation in progress
init_state_o  output  1  to datapath: 1 = use external state, 0 = use registered state
round_o  output  4  to datapath: current round index (constant select)
perm_en_o  output  1  to datapath: state register capture enable
done_o  output  1  one-cycle pulse; state register holds the permutation result

Behaviour:
- One clock; reset is asynchronous, active-low (clock_i, rst_i). All state is in flops cleared by rst_i=0.
- Reset values: state=IDLE, ready_o=1, busy_o=0, init_state_o=0, round_o=0, perm_en_o=0, done_o=0, round counter=0, latched sel=0.
- States: IDLE, FIRST, RUN, DONE.
- Round index: the start index is 12-N, with N=ROUNDS_A or ROUNDS_B (p12: 0..11; p8: 4..11). The last index is always 11. The counter is 4 bits and never wraps, because the FSM leaves RUN at 11.
- IDLE:
  - ready_o=1; all other outputs 0.
  - start_i=1 at edge E: latch sel_b_i, load the counter with 12-N, go to FIRST.
- FIRST (exactly 1 cycle):
  - init_state_o=1, perm_en_o=1, busy_o=1, round_o=12-N.
  - If 12-N=11 (N=1), go to DONE; otherwise increment the counter and go to RUN.
- RUN:
  - init_state_o=0, perm_en_o=1, busy_o=1, round_o=counter.
  - At counter=11, go to DONE; otherwise increment.
- DONE (exactly 1 cycle):
  - done_o=1, perm_en_o=0, busy_o=0, ready_o=0; go to IDLE.
- Latency: with start accepted at edge E, the rounds are captured at edges E+1..E+N and done_o is high in the cycle between edges E+N and E+N+1. Back-to-back requests have a minimum spacing of N+2 cycles.
- Ignored inputs:
  - start_i while ready_o=0 is ignored; it is not queued.
  - sel_b_i outside the accepting edge is ignored.
- Outputs are registered or decoded from the state register only; there is no combinational path from start_i.
- Reset mid-operation: the FSM returns to IDLE immediately (asynchronously). No done_o is produced for the aborted call.
- Illegal or unreachable state encodings recover to IDLE on the next edge.

Optional Feature:
Macro: ASCON_PERM_SEQ_ABORT_EN
- Defined:
  - Adds input abort_i (1 bit).
  - abort_i=1 in FIRST or RUN: at the next edge, go to IDLE with perm_en_o=0 and no done_o.
  - abort_i in IDLE or DONE has no effect.
  - If abort_i and the last-round condition occur in the same cycle, abort wins.
- Undefined: no abort_i port; each accepted request always runs to completion.

Test Plan:
- Reset, then start_i=1 with sel_b_i=0 at edge E -> init_state_o=1 only in the first cycle; round_o=0,1,...,11 on consecutive cycles; done_o=1 in the cycle after edge E+12; ready_o=1 again one cycle later.
- start_i=1 with sel_b_i=1 -> round_o=4..11 with perm_en_o=1 for 8 cycles; done_o exactly once; busy_o high for 8 cycles.
- Hold start_i=1 continuously, alternating sel_b_i -> requests accepted only when ready_o=1; spacing 14 cycles for p12 and 10 cycles for p8; a sel_b_i change mid-run does not alter round_o.
- Drive rst_i=0 asynchronously while round_o=6 -> all outputs return to reset values immediately; no done_o; a new start_i afterwards runs a full sequence.
- ROUNDS_A=1 -> a single FIRST cycle with round_o=11, then done_o on the next cycle.
- With ASCON_PERM_SEQ_ABORT_EN defined, assert abort_i at round_o=9 of a p12 call -> IDLE next edge, no done_o, ready_o=1.
